interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_pkg.sv | 18 +
 rtl/pic_winner_select.sv | 37 +++
 rtl/interrupt_sequencer.sv | 125 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared constants for the interrupt sequencer
package interrupt_sequencer_pkg;

    localparam int VEC_W_DEFAULT = 5;
    localparam int IDX_W         = 3;
    localparam int VEC_DATA_W    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK1 = 2'd2;

    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/pic_winner_select.sv
// rtl/pic_winner_select.sv - eligibility mask and lowest-index winner pick
module pic_winner_select
    import interrupt_sequencer_pkg::*;
(
    input  logic [7:0]       irr,
    input  logic [7:0]       imr,
    input  logic [7:0]       isr,
    output logic             any_eligible,
    output logic [IDX_W-1:0] winner
);

    logic [7:0] prio_mask;
    logic [7:0] eligible;
    logic       blocked;
    logic       found;

    always_comb begin
        prio_mask = 8'd0;
        blocked   = 1'b0;
        // A request is blocked by any in-service bit at its own or a higher priority.
        for (int i = 0; i < 8; i++) begin
            blocked      = blocked | isr[i];
            prio_mask[i] = ~blocked;
        end
        eligible     = irr & ~imr & prio_mask;
        any_eligible = |eligible;
        winner       = '0;
        found        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i] && !found) begin
                winner = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 8-line priority interrupt controller with two-pulse INTA sequence
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ir,
    input  logic                  ltim,
    input  logic                  imr_wr,
    input  logic [7:0]            imr_data,
    input  logic                  aeoi,
    input  logic                  eoi_cmd,
    input  logic                  eoi_specific,
    input  logic [2:0]            eoi_level,
    input  logic [VEC_W-1:0]      vector_base,
    input  logic                  inta_n,
    output logic                  int_o,
    output logic                  vec_valid,
    output logic [VEC_DATA_W-1:0] vec_data,
    output logic [7:0]            irr,
    output logic [7:0]            isr,
    output logic [7:0]            imr
);

    logic [1:0]       state;
    logic [7:0]       ir_prev;
    logic             inta_prev;
    logic [IDX_W-1:0] win_q;
    logic             spurious_q;

    logic             any_eligible;
    logic [IDX_W-1:0] winner;
    logic             inta_fall;
    logic             first_ack;
    logic             take;
    logic             second_ack;
    logic [7:0]       win_onehot;
    logic [7:0]       isr_set;
    logic [7:0]       irr_clr;
    logic [7:0]       eoi_clr;
    logic [7:0]       aeoi_clr;
    logic [7:0]       isr_next;
    logic [7:0]       irr_next;

    pic_winner_select u_winner (
        .irr          (irr),
        .imr          (imr),
        .isr          (isr),
        .any_eligible (any_eligible),
        .winner       (winner)
    );

    always_comb begin
        inta_fall  = inta_prev & ~inta_n;
        first_ack  = (state == ST_PEND) && inta_fall;
        take       = first_ack && any_eligible;
        second_ack = (state == ST_ACK1) && inta_fall;
        win_onehot = 8'd1 << winner;
        isr_set    = take ? win_onehot : 8'd0;
        irr_clr    = (take && !ltim) ? win_onehot : 8'd0;
        eoi_clr    = 8'd0;
        if (eoi_cmd) begin
            eoi_clr = eoi_specific ? (8'd1 << eoi_level) : lowest_onehot(isr);
        end
        aeoi_clr   = (second_ack && aeoi && !spurious_q) ? (8'd1 << win_q) : 8'd0;
        // Sets are OR-ed in last so they win over same-cycle clears.
        isr_next   = (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
        irr_next   = ltim ? ir : ((irr & ~irr_clr) | (ir & ~ir_prev));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ir_prev    <= 8'd0;
            inta_prev  <= 1'b1;
            win_q      <= '0;
            spurious_q <= 1'b0;
            irr        <= 8'd0;
            isr        <= 8'd0;
            imr        <= 8'hFF;
            int_o      <= 1'b0;
            vec_valid  <= 1'b0;
            vec_data   <= '0;
        end else begin
            ir_prev   <= ir;
            inta_prev <= inta_n;
            irr       <= irr_next;
            isr       <= isr_next;
            if (imr_wr) begin
                imr <= imr_data;
            end
            int_o     <= any_eligible &&
                         ((state == ST_IDLE) || ((state == ST_PEND) && !inta_fall));
            vec_valid <= second_ack;
            if (second_ack) begin
                vec_data <= VEC_DATA_W'({vector_base, win_q});
            end
            case (state)
                ST_IDLE: begin
                    if (any_eligible) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (inta_fall) begin
                        state      <= ST_ACK1;
                        win_q      <= take ? winner : SPURIOUS_IDX;
                        spurious_q <= !any_eligible;
                    end else if (!any_eligible) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACK1: begin
                    if (inta_fall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir;
    logic       ltim;
    logic       imr_wr;
    logic [7:0] imr_data;
    logic       aeoi;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       int_o;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;

    int errors = 0;
    int checks = 0;
    int vec_count = 0;
    int vec_before;

    interrupt_sequencer #(.VEC_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .ltim         (ltim),
        .imr_wr       (imr_wr),
        .imr_data     (imr_data),
        .aeoi         (aeoi),
        .eoi_cmd      (eoi_cmd),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .vector_base  (vector_base),
        .inta_n       (inta_n),
        .int_o        (int_o),
        .vec_valid    (vec_valid),
        .vec_data     (vec_data),
        .irr          (irr),
        .isr          (isr),
        .imr          (imr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vec_valid === 1'b1) vec_count++;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ir(input int idx);
        ir      = 8'd0;
        ir[idx] = 1'b1;
        tick();
        ir      = 8'd0;
    endtask

    task automatic inta_edge();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
    endtask

    task automatic write_imr(input logic [7:0] v);
        imr_wr   = 1'b1;
        imr_data = v;
        tick();
        imr_wr   = 1'b0;
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl);
        eoi_cmd      = 1'b1;
        eoi_specific = specific;
        eoi_level    = lvl;
        tick();
        eoi_cmd      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ir = 8'd0; ltim = 1'b0; imr_wr = 1'b0; imr_data = 8'd0;
        aeoi = 1'b0; eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        vector_base = 5'h00; inta_n = 1'b1;
        tick(3);
        check("rst_irr", irr, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_imr", imr, 8'hFF);
        check("rst_int_o", 8'(int_o), 8'h00);
        check("rst_vec_valid", 8'(vec_valid), 8'h00);
        check("rst_vec_data", vec_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // basic edge-triggered acknowledge of IR3
        vector_base = 5'h08;
        write_imr(8'h00);
        check("s1_imr", imr, 8'h00);
        pulse_ir(3);
        check("s1_irr_set", irr, 8'h08);
        check("s1_int_o_early", 8'(int_o), 8'h00);
        tick();
        check("s1_int_o_rise", 8'(int_o), 8'h01);
        inta_edge();
        check("s1_isr_ack1", isr, 8'h08);
        check("s1_irr_ack1", irr, 8'h00);
        check("s1_int_o_ack1", 8'(int_o), 8'h00);
        tick();
        inta_edge();
        check("s1_vec_valid", 8'(vec_valid), 8'h01);
        check("s1_vec_data", vec_data, 8'h43);
        tick();
        check("s1_vec_valid_drop", 8'(vec_valid), 8'h00);
        check("s1_isr_end", isr, 8'h08);

        // lower priority blocked by in-service IR3, higher priority nests
        pulse_ir(5);
        tick(2);
        check("s2_int_o_ir5", 8'(int_o), 8'h00);
        check("s2_irr_ir5", irr, 8'h20);
        pulse_ir(1);
        tick();
        check("s2_int_o_ir1", 8'(int_o), 8'h01);
        inta_edge();
        check("s2_isr_ack1", isr, 8'h0A);
        check("s2_irr_ack1", irr, 8'h20);
        tick();
        inta_edge();
        check("s2_vec_valid", 8'(vec_valid), 8'h01);
        check("s2_vec_data", vec_data, 8'h41);
        tick();

        // EOI handling; IR5 masked so it stays pending but never requests
        write_imr(8'hFF);
        eoi(1'b0, 3'd0);
        check("s3_eoi_ns", isr, 8'h08);
        eoi(1'b1, 3'd3);
        check("s3_eoi_sp", isr, 8'h00);
        eoi(1'b0, 3'd0);
        check("s3_eoi_empty_ns", isr, 8'h00);
        eoi(1'b1, 3'd6);
        check("s3_eoi_empty_sp", isr, 8'h00);
        check("s3_irr_masked", irr, 8'h20);
        check("s3_int_o_masked", 8'(int_o), 8'h00);

        // level mode: request withdrawn before INTA gives spurious vector
        ltim = 1'b1;
        tick(2);
        check("s4_irr_level_clr", irr, 8'h00);
        write_imr(8'h00);
        ir[2] = 1'b1;
        tick();
        check("s4_irr_level", irr, 8'h04);
        tick();
        check("s4_int_o", 8'(int_o), 8'h01);
        ir = 8'd0;
        tick();
        inta_edge();
        check("s4_isr_spur", isr, 8'h00);
        check("s4_int_o_spur", 8'(int_o), 8'h00);
        tick();
        inta_edge();
        check("s4_vec_valid", 8'(vec_valid), 8'h01);
        check("s4_vec_data", vec_data, 8'h47);
        tick();
        check("s4_isr_end", isr, 8'h00);

        // automatic EOI
        ltim = 1'b0;
        aeoi = 1'b1;
        tick();
        pulse_ir(0);
        tick();
        check("s5_int_o", 8'(int_o), 8'h01);
        inta_edge();
        check("s5_isr_ack1", isr, 8'h01);
        tick();
        check("s5_isr_hold", isr, 8'h01);
        inta_edge();
        check("s5_vec_valid", 8'(vec_valid), 8'h01);
        check("s5_vec_data", vec_data, 8'h40);
        check("s5_isr_aeoi", isr, 8'h00);
        tick();
        aeoi = 1'b0;

        // reset between the two INTA pulses
        pulse_ir(4);
        tick();
        check("s6_int_o", 8'(int_o), 8'h01);
        inta_edge();
        check("s6_isr_ack1", isr, 8'h10);
        vec_before = vec_count;
        tick();
        rst_n = 1'b0;
        #1;
        check("s6_irr_rst", irr, 8'h00);
        check("s6_isr_rst", isr, 8'h00);
        check("s6_imr_rst", imr, 8'hFF);
        check("s6_int_o_rst", 8'(int_o), 8'h00);
        check("s6_vec_data_rst", vec_data, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick();
        inta_edge();
        tick(3);
        check("s6_no_vec", 8'(vec_count - vec_before), 8'h00);
        check("s6_vec_valid", 8'(vec_valid), 8'h00);
        check("s6_isr_after", isr, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
